quad_demod_accum: RTL and testbench

- Consumer of the sin/cos phase-index counter: square-wave quadrature demodulator for the lock-in path.
- Each cycle it mixes one ADC sample by ±1 reference signs derived from SIN_COUNTER/COS_COUNTER.
- It accumulates I and Q over PERIODS full reference periods, aligned to PHASE_START.
- Each finished I/Q pair is presented to the FT245 writer on a valid/ready handshake.

---
 rtl/quad_demod_accum.sv | 115 +++++++++++
 tb/tb_quad_demod_accum.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_demod_accum.sv
// Square-wave quadrature demodulator: mixes each ADC sample by +/-1 sin/cos reference
// signs and accumulates I/Q over PERIODS reference periods. Optional macro: QDA_OFFSET_BINARY_EN.
module quad_demod_accum #(
  parameter int DATA_W    = 12,
  parameter int THRESHOLD = 39,
  parameter int PERIODS   = 16,
  parameter int ACC_W     = 24
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic [DATA_W-1:0]       ADC_DATA,
  input  logic [7:0]              SIN_COUNTER,
  input  logic [7:0]              COS_COUNTER,
  input  logic                    PHASE_START,
  output logic signed [ACC_W-1:0] I_OUT,
  output logic signed [ACC_W-1:0] Q_OUT,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic                    OVERRUN
);

  localparam int             PC_W     = (PERIODS > 1) ? $clog2(PERIODS) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PERIODS - 1);
  localparam logic [7:0]     HALF_IDX = 8'((THRESHOLD + 1) / 2);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic [PC_W-1:0]         period_cnt;

  logic [DATA_W-1:0]       sample;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] mix_i;
  logic signed [ACC_W-1:0] mix_q;
  logic                    dump;
  logic                    handshake;

`ifdef QDA_OFFSET_BINARY_EN
  // Offset binary to two's complement: flip the MSB.
  assign sample = {~ADC_DATA[DATA_W-1], ADC_DATA[DATA_W-2:0]};
`else
  assign sample = ADC_DATA;
`endif

  assign sample_ext = {{(ACC_W - DATA_W){sample[DATA_W-1]}}, sample};
  assign mix_i      = (SIN_COUNTER < HALF_IDX) ? sample_ext : -sample_ext;
  assign mix_q      = (COS_COUNTER < HALF_IDX) ? sample_ext : -sample_ext;

  assign dump      = (state == ACCUM) && EN && PHASE_START && (period_cnt == PC_LAST);
  assign handshake = OUT_VALID && OUT_READY;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      acc_i      <= '0;
      acc_q      <= '0;
      period_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          acc_i      <= '0;
          acc_q      <= '0;
          period_cnt <= '0;
          if (EN && PHASE_START) begin
            state <= ACCUM;
            acc_i <= mix_i;
            acc_q <= mix_q;
          end
        end
        ACCUM: begin
          if (!EN) begin
            state      <= IDLE;
            acc_i      <= '0;
            acc_q      <= '0;
            period_cnt <= '0;
          end else if (dump) begin
            // The terminal sample opens the next window, so no sample is lost.
            acc_i      <= mix_i;
            acc_q      <= mix_q;
            period_cnt <= '0;
          end else begin
            acc_i <= acc_i + mix_i;
            acc_q <= acc_q + mix_q;
            if (PHASE_START) period_cnt <= period_cnt + PC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      I_OUT     <= '0;
      Q_OUT     <= '0;
      OUT_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else if (dump) begin
      // A handshake on the dump edge frees the slot for the new result.
      if (!OUT_VALID || handshake) begin
        I_OUT     <= acc_i;
        Q_OUT     <= acc_q;
        OUT_VALID <= 1'b1;
      end else begin
        OVERRUN <= 1'b1;
      end
    end else if (handshake) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_demod_accum.sv
// Randomized self-checking bench for quad_demod_accum against a window-sum reference model.
module tb_quad_demod_accum;
  localparam int DATA_W = 12, THRESHOLD = 39, PERIODS = 2, ACC_W = 24;
  localparam int PER = THRESHOLD + 1;

  logic                    clk, rst_n, en, ps, rdy;
  logic [DATA_W-1:0]       adc;
  logic [7:0]              sin_c, cos_c;
  logic signed [ACC_W-1:0] i_out, q_out;
  logic                    out_valid, overrun;

  int errors = 0, checks = 0;
  int ph = 0, mode = 0;

  // reference model state
  int win_i[$], win_q[$];
  int starts;
  bit active;
  logic signed [ACC_W-1:0] m_i, m_q;
  bit m_valid, m_ovr;

  quad_demod_accum #(.DATA_W(DATA_W), .THRESHOLD(THRESHOLD), .PERIODS(PERIODS), .ACC_W(ACC_W)) dut (
    .CLK(clk), .RST(rst_n), .EN(en), .ADC_DATA(adc), .SIN_COUNTER(sin_c), .COS_COUNTER(cos_c),
    .PHASE_START(ps), .I_OUT(i_out), .Q_OUT(q_out), .OUT_VALID(out_valid), .OUT_READY(rdy),
    .OVERRUN(overrun));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_W-1:0] square(input bit positive);
`ifdef QDA_OFFSET_BINARY_EN
    return positive ? 12'h864 : 12'h79C;
`else
    return positive ? 12'd100 : 12'hF9C;
`endif
  endfunction

  task automatic drive_inputs();
    sin_c = 8'(ph);
    cos_c = 8'((ph + 10) % PER);
    ps    = (ph == 0);
    case (mode)
      0: adc = square(1'b1);
      1: adc = square(ph < PER / 2);
      2: adc = square(((ph + 10) % PER) < PER / 2);
      default: adc = DATA_W'($urandom);
    endcase
  endtask

  task automatic model_reset();
    active = 0; starts = 0;
    win_i.delete(); win_q.delete();
    m_i = '0; m_q = '0; m_valid = 0; m_ovr = 0;
  endtask

  // Window-level model: collect each window's products, sum them when the window closes.
  task automatic model_update();
    logic signed [DATA_W-1:0] sv;
    int s, pi, pq, si, sq;
    bit closed;
    sv = adc;
`ifdef QDA_OFFSET_BINARY_EN
    sv = adc ^ 12'h800;
`endif
    s  = int'(sv);
    pi = (int'(sin_c) < PER / 2) ? s : -s;
    pq = (int'(cos_c) < PER / 2) ? s : -s;
    closed = 0; si = 0; sq = 0;
    if (!active) begin
      if (en && ps) begin active = 1; win_i = '{pi}; win_q = '{pq}; starts = 1; end
    end else if (!en) begin
      active = 0; win_i.delete(); win_q.delete();
    end else if (ps && starts == PERIODS) begin
      foreach (win_i[k]) si += win_i[k];
      foreach (win_q[k]) sq += win_q[k];
      closed = 1;
      win_i = '{pi}; win_q = '{pq}; starts = 1;
    end else begin
      win_i.push_back(pi); win_q.push_back(pq);
      if (ps) starts++;
    end
    if (closed) begin
      if (m_valid && !rdy) m_ovr = 1;
      else begin m_i = ACC_W'(si); m_q = ACC_W'(sq); m_valid = 1; end
    end else if (m_valid && rdy) m_valid = 0;
  endtask

  task automatic cycle();
    drive_inputs();
    @(posedge clk);
    model_update();
    ph = (ph + 1) % PER;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic wait_valid(input int max, input string name);
    int n = 0;
    do begin cycle(); n++; end while (!out_valid && n < max);
    if (!out_valid) begin
      errors++; checks++;
      $display("FAIL %s: timeout, out_valid=%0b after %0d cycles, required 1", name, out_valid, n);
    end
  endtask

  task automatic test_reset();
    en = 0; rdy = 0; mode = 0;
    drive_inputs();
    apply_reset();
    checks++;
    if ({i_out, q_out, out_valid, overrun} !== '0) begin
      errors++;
      $display("FAIL reset: i=%0d q=%0d v=%0b ovr=%0b, required all 0", i_out, q_out, out_valid, overrun);
    end
  endtask

  task automatic test_first_result();
    int n_ps = 0, n = 0;
    bit ps_now = 0;
    en = 1; rdy = 1; mode = 0;
    while (!out_valid && n < 300) begin
      ps_now = (ph == 0);
      cycle();
      if (ps_now) n_ps++;
      n++;
    end
    checks++;
    if (!(out_valid && ps_now && n_ps == 3)) begin
      errors++;
      $display("FAIL first_latency: valid=%0b after %0d phase starts (last edge ps=%0b), required 1 after 3",
               out_valid, n_ps, ps_now);
    end
    checks++;
    if (i_out !== 0 || q_out !== 0) begin
      errors++;
      $display("FAIL first_const: i=%0d q=%0d, required 0 0", i_out, q_out);
    end
  endtask

  task automatic test_square(input int md, input int exp_i, input int exp_q, input string name);
    mode = md; rdy = 1;
    wait_valid(200, name);
    wait_valid(200, name);
    checks++;
    if (i_out !== ACC_W'(exp_i) || q_out !== ACC_W'(exp_q)) begin
      errors++;
      $display("FAIL %s: i=%0d q=%0d, required %0d %0d", name, i_out, q_out, exp_i, exp_q);
    end
    checks++;
    if (i_out !== m_i || q_out !== m_q) begin
      errors++;
      $display("FAIL %s_model: i=%0d q=%0d, model %0d %0d", name, i_out, q_out, m_i, m_q);
    end
  endtask

  task automatic test_overrun();
    logic signed [ACC_W-1:0] i1, q1;
    bit stable = 1;
    en = 1; rdy = 0; mode = 3;
    apply_reset();
    wait_valid(300, "overrun_first");
    i1 = i_out; q1 = q_out;
    checks++;
    if (i_out !== m_i || q_out !== m_q) begin
      errors++;
      $display("FAIL overrun_first: i=%0d q=%0d, model %0d %0d", i_out, q_out, m_i, m_q);
    end
    for (int k = 0; k < PERIODS * PER + 2; k++) begin
      cycle();
      if (i_out !== i1 || q_out !== q1 || !out_valid) stable = 0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL overrun_hold: i=%0d q=%0d v=%0b, required %0d %0d 1", i_out, q_out, out_valid, i1, q1);
    end
    checks++;
    if (overrun !== 1'b1 || m_ovr !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: ovr=%0b model=%0b, required 1", overrun, m_ovr);
    end
    rdy = 1;
    cycle();
    rdy = 0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_handshake: valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_dump_handshake();
    int n = 0;
    en = 1; rdy = 0; mode = 3;
    apply_reset();
    wait_valid(300, "dump_hs_first");
    while (!(ph == 0 && active && starts == PERIODS) && n < 200) begin cycle(); n++; end
    rdy = 1;
    cycle();
    rdy = 0;
    checks++;
    if (out_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL dump_hs_flags: valid=%0b ovr=%0b, required 1 0", out_valid, overrun);
    end
    checks++;
    if (i_out !== m_i || q_out !== m_q || !m_valid) begin
      errors++;
      $display("FAIL dump_hs_data: i=%0d q=%0d, model %0d %0d", i_out, q_out, m_i, m_q);
    end
  endtask

  task automatic test_enable_abort();
    int n = 0;
    bit early = 0;
    en = 1; rdy = 1; mode = 1;
    apply_reset();
    while (!(active && ph == 20) && n < 200) begin cycle(); n++; end
    en = 0;
    cycle();
    en = 1;
    n = 0;
    do begin
      cycle(); n++;
      if (out_valid && n < 100) early = 1;
    end while (!out_valid && n < 200);
    checks++;
    if (early || n != 100) begin
      errors++;
      $display("FAIL en_abort_latency: valid after %0d cycles (early=%0b), required 100", n, early);
    end
    checks++;
    if (i_out !== 24'sd8000 || q_out !== 0 || i_out !== m_i) begin
      errors++;
      $display("FAIL en_abort_data: i=%0d q=%0d, required 8000 0", i_out, q_out);
    end
  endtask

  task automatic test_async_reset();
    en = 1; rdy = 0; mode = 1;
    wait_valid(300, "async_pre");
    repeat (10) cycle();
    rst_n = 0;
    model_reset();
    #2;
    checks++;
    if ({i_out, q_out, out_valid, overrun} !== '0) begin
      errors++;
      $display("FAIL async_reset: i=%0d q=%0d v=%0b ovr=%0b, required all 0", i_out, q_out, out_valid, overrun);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    en = 1; mode = 3;
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      rdy = ($urandom_range(0, 3) != 0);
      cycle();
      checks++;
      if (out_valid !== m_valid || overrun !== m_ovr || (m_valid && (i_out !== m_i || q_out !== m_q))) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL b2b cycle %0d: v=%0b ovr=%0b i=%0d q=%0d, model v=%0b ovr=%0b i=%0d q=%0d",
                   k, out_valid, overrun, i_out, q_out, m_valid, m_ovr, m_i, m_q);
      end
    end
    rdy = 0;
  endtask

  initial begin
    rst_n = 1; en = 0; rdy = 0;
    drive_inputs();
    model_reset();
    test_reset();
    test_first_result();
    test_square(1, 8000, 0, "sin_square");
    test_square(2, 0, 8000, "cos_square");
    test_overrun();
    test_dump_handshake();
    test_enable_abort();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
